// File: rtl/vga_pattern_ctrl.sv
// vga_pattern_ctrl
// Front-end for the VGA pattern generator. It debounces the pushbuttons,
// queues the resulting requests and applies pattern changes only at frame
// start. A long pb_enter press toggles an auto-cycle mode.

// Debounce FSM for one synchronised button level.
// It emits one-cycle press/release pulses and reports the held state.
module vga_pattern_ctrl_debounce #(
  parameter logic [15:0] CYCLES = 16'd50000
) (
  input  logic vga_clk,
  input  logic rst_n,
  input  logic level,
  output logic press,
  output logic rel,
  output logic held
);

  typedef enum logic [1:0] {REL, REL_CHK, PRS, PRS_CHK} db_state_t;

  db_state_t   state;
  logic [15:0] cnt;

  // The level must stay stable for CYCLES cycles before a transition is accepted.
  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= REL;
      cnt   <= 16'd0;
      press <= 1'b0;
      rel   <= 1'b0;
    end else begin
      press <= 1'b0;
      rel   <= 1'b0;
      case (state)
        REL: begin
          if (level) begin
            state <= REL_CHK;
            cnt   <= 16'd0;
          end
        end
        REL_CHK: begin
          if (!level) begin
            state <= REL;
          end else if (cnt == CYCLES - 16'd1) begin
            state <= PRS;
            press <= 1'b1;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        PRS: begin
          if (!level) begin
            state <= PRS_CHK;
            cnt   <= 16'd0;
          end
        end
        PRS_CHK: begin
          if (level) begin
            state <= PRS;
          end else if (cnt == CYCLES - 16'd1) begin
            state <= REL;
            rel   <= 1'b1;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: state <= REL;
      endcase
    end
  end

  // Held covers the whole pressed phase, including the release-check window.
  assign held = (state == PRS) || (state == PRS_CHK);

endmodule

module vga_pattern_ctrl #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter logic [7:0]  AUTO_FRAMES     = 8'd60,
  parameter logic [7:0]  LONG_FRAMES     = 8'd120
) (
  input  logic       vga_clk,
  input  logic       rst_n,
  input  logic       pb_up,
  input  logic       pb_enter,
  input  logic       v_sync,
  output logic [2:0] color_pattern,
  output logic       pattern_update,
  output logic       pattern_reset,
  output logic       auto_mode
);

  logic       up_s1, up_s2, en_s1, en_s2;
  logic       v_sync_r;
  logic       frame_start;
  logic       up_press, up_rel, up_held;
  logic       en_press, en_rel, en_held;
  logic       up_unused;
  logic       pend_up, pend_rst;
  logic       long_done;
  logic [7:0] hold_cnt;
  logic [7:0] hold_nxt;
  logic [7:0] auto_cnt;
  logic       long_hit;

  // Two-flop synchronisers for the raw buttons, plus the v_sync edge register.
  // NOTE: non-blocking assignments make every flop sample the old value of its
  // predecessor; blocking here would collapse the chain into a single flop.
  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      up_s1    <= 1'b0;
      up_s2    <= 1'b0;
      en_s1    <= 1'b0;
      en_s2    <= 1'b0;
      v_sync_r <= 1'b1;
    end else begin
      up_s1    <= pb_up;
      up_s2    <= up_s1;
      en_s1    <= pb_enter;
      en_s2    <= en_s1;
      v_sync_r <= v_sync;
    end
  end

  assign frame_start = v_sync_r & ~v_sync;

  vga_pattern_ctrl_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_up (
    .vga_clk (vga_clk),
    .rst_n   (rst_n),
    .level   (up_s2),
    .press   (up_press),
    .rel     (up_rel),
    .held    (up_held)
  );

  vga_pattern_ctrl_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_enter (
    .vga_clk (vga_clk),
    .rst_n   (rst_n),
    .level   (en_s2),
    .press   (en_press),
    .rel     (en_rel),
    .held    (en_held)
  );

  // The up button only needs its press pulse.
  assign up_unused = up_rel ^ up_held;

  // A long press is recognised on the frame start that brings hold_cnt to LONG_FRAMES.
  assign hold_nxt = (hold_cnt == 8'hFF) ? hold_cnt : hold_cnt + 8'd1;
  assign long_hit = en_held & frame_start & ~long_done & (hold_nxt == LONG_FRAMES);

  // Request queueing, long-press tracking and the frame-start apply step.
  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      color_pattern  <= 3'd0;
      pattern_update <= 1'b0;
      pattern_reset  <= 1'b0;
      auto_mode      <= 1'b0;
      pend_up        <= 1'b0;
      pend_rst       <= 1'b0;
      long_done      <= 1'b0;
      hold_cnt       <= 8'd0;
      auto_cnt       <= 8'd0;
    end else begin
      pattern_update <= 1'b0;
      pattern_reset  <= 1'b0;

      // Apply step: reset beats manual step beats auto step.
      if (frame_start) begin
        if (pend_rst) begin
          color_pattern  <= 3'd0;
          pattern_update <= 1'b1;
          pattern_reset  <= 1'b1;
          pend_rst       <= 1'b0;
          pend_up        <= 1'b0;
          auto_cnt       <= 8'd0;
        end else if (pend_up) begin
          color_pattern  <= color_pattern + 3'd1;
          pattern_update <= 1'b1;
          pend_up        <= 1'b0;
          auto_cnt       <= 8'd0;
        end else if (auto_mode && auto_cnt == AUTO_FRAMES - 8'd1) begin
          color_pattern  <= color_pattern + 3'd1;
          pattern_update <= 1'b1;
          auto_cnt       <= 8'd0;
        end else if (auto_mode) begin
          auto_cnt <= auto_cnt + 8'd1;
        end
      end

      // Hold tracking while pb_enter is down.
      if (en_press) begin
        hold_cnt  <= 8'd0;
        long_done <= 1'b0;
      end else if (en_held && frame_start) begin
        hold_cnt <= hold_nxt;
      end

      if (long_hit) begin
        auto_mode <= ~auto_mode;
        long_done <= 1'b1;
        auto_cnt  <= 8'd0;
      end

      // New requests land after the apply step, so a press coinciding with
      // frame start is held over to the next frame.
      if (up_press) begin
        pend_up <= 1'b1;
      end
      if (en_rel && !long_done && !long_hit) begin
        pend_rst <= 1'b1;
      end

      // The auto interval counter rests at zero while auto mode is off.
      if (!auto_mode && !long_hit) begin
        auto_cnt <= 8'd0;
      end
    end
  end

endmodule

// File: doc/vga_pattern_ctrl.md
Name: vga_pattern_ctrl

Overview:
- Front-end controller that sequences the colour-pattern selection fed to the VGA timing/RGB generator.
- Debounces the raw pb_up / pb_enter pushbuttons and queues the resulting requests.
- Applies pattern changes only at frame start (falling edge of active-low v_sync), so a frame never shows two patterns.
- Adds an auto-cycle mode, toggled by a long press of pb_enter, that advances the pattern every AUTO_FRAMES frames.

Parameters:
- DEBOUNCE_CYCLES, 16'd50000, number of vga_clk cycles a button level must stay stable to be accepted (2 ms at 25 MHz).
- AUTO_FRAMES, 8'd60, frames per pattern step in auto mode; legal range 1..255.
- LONG_FRAMES, 8'd120, frame starts pb_enter must stay held to count as a long press; legal range 1..255.

Ports:
- vga_clk  input  1  pixel clock, 25 MHz; all logic is on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- pb_up  input  1  raw pushbuttons, asynchronous, active-high.
- pb_enter  input  1  raw pushbuttons, asynchronous, active-high.
- v_sync  input  1  vertical sync from the timing generator, active-low, vga_clk domain.
- color_pattern  output  3  current pattern index (0 = white … 7 = magenta).
- pattern_update  output  1  one-cycle pulse when color_pattern is written, including a reset to 0.
- pattern_reset  output  1  one-cycle pulse when a short pb_enter press is applied; drives the timing generator restart.
- auto_mode  output  1  high while auto-cycle is active.

Behaviour:
- **Reset:** while rst_n=0, all registers clear asynchronously.
  - color_pattern=0, pattern_update=0, pattern_reset=0, auto_mode=0.
  - Pending flags and all counters = 0.
  - Synchroniser flops = 0; v_sync_r = 1.
- **Input sync:** pb_up and pb_enter each pass through a 2-flop synchroniser.
- **Frame start:** frame_start = v_sync_r & ~v_sync, where v_sync_r is v_sync delayed by one cycle. It is a combinational 1-cycle pulse.
- **Debounce FSM** (one instance per button), states REL, REL_CHK, PRS, PRS_CHK, with a 16-bit counter:
  - REL: if synced level = 1, go to REL_CHK and clear the counter.
  - REL_CHK: if level = 0, go to REL. Else, when counter == DEBOUNCE_CYCLES-1, go to PRS and emit a 1-cycle press pulse. Else counter+1.
  - PRS: if level = 0, go to PRS_CHK and clear the counter.
  - PRS_CHK: if level = 1, go to PRS. Else, when counter == DEBOUNCE_CYCLES-1, go to REL and emit a 1-cycle release pulse. Else counter+1.
- **pb_up press:** sets pend_up. It holds at most one request; further presses before it is applied are absorbed.
- **pb_enter hold tracking:**
  - A press clears hold_cnt (8-bit) and long_done.
  - While in PRS or PRS_CHK, each frame_start increments hold_cnt, saturating at 255.
  - When hold_cnt reaches LONG_FRAMES with long_done=0: toggle auto_mode in that cycle, set long_done, clear auto_cnt.
  - On release: if long_done=0, set pend_rst; if long_done=1, do nothing.
- **Apply step.** On each frame_start, in priority order (registered, so outputs change the cycle after frame_start):
  1. pend_rst: color_pattern←0; pattern_reset=1 and pattern_update=1 for 1 cycle; clear pend_rst and pend_up; auto_cnt←0.
  2. Else pend_up: color_pattern←color_pattern+1 (7 wraps to 0); pattern_update=1; clear pend_up; auto_cnt←0.
  3. Else if auto_mode and auto_cnt == AUTO_FRAMES-1: color_pattern+1 with wrap; pattern_update=1; auto_cnt←0.
  4. Else if auto_mode: auto_cnt+1.
- auto_cnt is held at 0 while auto_mode=0.
- **Simultaneous events:**
  - A press pulse arriving in the same cycle as frame_start sets its pending flag; it is applied at the next frame_start, not the current one.
  - pend_rst beats pend_up.
  - A manual step resets the auto interval.
- No output changes except on frame_start or reset, apart from auto_mode, which changes on the long-press cycle.
- Reset mid-debounce or mid-hold: all state discarded; the button must be re-pressed and re-stabilised.

Test Plan (bench overrides DEBOUNCE_CYCLES=4, AUTO_FRAMES=3, LONG_FRAMES=2; frame = v_sync low pulse every 100 cycles):
- **Reset:** hold rst_n=0 for 5 cycles, with pb_up and pb_enter asserted → color_pattern=0, auto_mode=0, no pulses; after release, outputs stay 0 until the buttons pass debounce.
- **Glitch:** pb_up high 3 cycles then low → no pend_up; at the next frame_start color_pattern stays 0 and pattern_update stays 0.
- **Pattern step:** clean pb_up press held 10 cycles, mid-frame → color_pattern 0→1 exactly one cycle after the next v_sync falling edge, with a single pattern_update pulse. Eight such presses wrap it back to 0.
- **Short enter:** with color_pattern=5, press pb_enter for 20 cycles (under 2 frame starts) → after release, the next frame_start gives color_pattern=0 with pattern_reset and pattern_update both high for 1 cycle; auto_mode unchanged.
- **Auto mode:** hold pb_enter across 2 frame starts → auto_mode=1 on the second; release gives no reset. The pattern then increments every 3rd frame start (0→1→2…). Another long press turns auto_mode off and the pattern freezes.
- **Priority:** pend_up and pend_rst both set before the same frame_start → color_pattern=0, pattern_reset pulse, pend_up cleared; the following frame shows no increment.
